// File: rtl/sniffer_pkg.sv
// Shared definitions for the comparator configuration loader: register map,
// control/status bit positions, loader state encoding and URL length saturation.
package sniffer_pkg;

    localparam logic [3:0] ADDR_PORT    = 4'd0;
    localparam logic [3:0] ADDR_IP      = 4'd1;
    localparam logic [3:0] ADDR_MAC_LO  = 4'd2;
    localparam logic [3:0] ADDR_MAC_HI  = 4'd3;
    localparam logic [3:0] ADDR_URL0    = 4'd4;
    localparam logic [3:0] ADDR_URL1    = 4'd5;
    localparam logic [3:0] ADDR_URL2    = 4'd6;
    localparam logic [3:0] ADDR_URL3    = 4'd7;
    localparam logic [3:0] ADDR_URL_LEN = 4'd8;
    localparam logic [3:0] ADDR_CTRL    = 4'd9;
    localparam logic [3:0] ADDR_STATUS  = 4'd10;

    localparam int CTRL_COMMIT_BIT    = 0;
    localparam int CTRL_CLEAR_BIT     = 1;
    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_VALID_BIT   = 1;
    localparam int STATUS_COUNT_LSB   = 8;

    localparam logic [4:0] URL_LEN_MAX = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_LOAD    = 2'd2,
        ST_DONE    = 2'd3
    } loader_state_e;

    // URL targets are at most 16 bytes; larger lengths clamp rather than wrap.
    function automatic logic [4:0] sat_url_len(input logic [31:0] v);
        if (v > 32'd16) begin
            return URL_LEN_MAX;
        end
        return v[4:0];
    endfunction

endpackage

// File: rtl/cfg_shadow_file.sv
// Shadow register file: address decode for host writes, clear, URL length
// saturation and the registered read mux (reads always show shadow contents).
module cfg_shadow_file (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [3:0]   address,
    input  logic [31:0]  writedata,
    input  logic         commit_pending,
    input  logic         cfg_valid,
    input  logic [7:0]   commit_count,
    output logic [31:0]  readdata,
    output logic         commit_req,
    output logic [15:0]  sh_port,
    output logic [31:0]  sh_ip,
    output logic [47:0]  sh_mac,
    output logic [127:0] sh_url,
    output logic [4:0]   sh_url_len
);
    import sniffer_pkg::*;

    logic [15:0]  port_q, port_d;
    logic [31:0]  ip_q, ip_d;
    logic [47:0]  mac_q, mac_d;
    logic [127:0] url_q, url_d;
    logic [4:0]   url_len_q, url_len_d;
    logic [31:0]  readdata_q, readdata_d;
    logic [31:0]  rdata_mux;
    logic         ctrl_wr;

    assign ctrl_wr    = wr_en && (address == ADDR_CTRL);
    assign commit_req = ctrl_wr && writedata[CTRL_COMMIT_BIT];

    // Shadow next-state: a clear wins over everything so clear+commit loads zeros.
    always_comb begin
        port_d    = port_q;
        ip_d      = ip_q;
        mac_d     = mac_q;
        url_d     = url_q;
        url_len_d = url_len_q;
        if (ctrl_wr && writedata[CTRL_CLEAR_BIT]) begin
            port_d    = '0;
            ip_d      = '0;
            mac_d     = '0;
            url_d     = '0;
            url_len_d = '0;
        end else if (wr_en) begin
            case (address)
                ADDR_PORT:    port_d         = writedata[15:0];
                ADDR_IP:      ip_d           = writedata;
                ADDR_MAC_LO:  mac_d[31:0]    = writedata;
                ADDR_MAC_HI:  mac_d[47:32]   = writedata[15:0];
                ADDR_URL0:    url_d[127:96]  = writedata;
                ADDR_URL1:    url_d[95:64]   = writedata;
                ADDR_URL2:    url_d[63:32]   = writedata;
                ADDR_URL3:    url_d[31:0]    = writedata;
                ADDR_URL_LEN: url_len_d      = sat_url_len(writedata);
                default: ;
            endcase
        end
    end

    // Read mux; unused bits and unmapped addresses return zero.
    always_comb begin
        rdata_mux = '0;
        case (address)
            ADDR_PORT:    rdata_mux[15:0] = port_q;
            ADDR_IP:      rdata_mux       = ip_q;
            ADDR_MAC_LO:  rdata_mux       = mac_q[31:0];
            ADDR_MAC_HI:  rdata_mux[15:0] = mac_q[47:32];
            ADDR_URL0:    rdata_mux       = url_q[127:96];
            ADDR_URL1:    rdata_mux       = url_q[95:64];
            ADDR_URL2:    rdata_mux       = url_q[63:32];
            ADDR_URL3:    rdata_mux       = url_q[31:0];
            ADDR_URL_LEN: rdata_mux[4:0]  = url_len_q;
            ADDR_STATUS: begin
                rdata_mux[STATUS_PENDING_BIT]          = commit_pending;
                rdata_mux[STATUS_VALID_BIT]            = cfg_valid;
                rdata_mux[STATUS_COUNT_LSB +: 8]       = commit_count;
            end
            default: ;
        endcase
        readdata_d = rd_en ? rdata_mux : readdata_q;
    end

    // Shadow and read-data registers; read sees pre-write values on a same-cycle write.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            port_q     <= '0;
            ip_q       <= '0;
            mac_q      <= '0;
            url_q      <= '0;
            url_len_q  <= '0;
            readdata_q <= '0;
        end else begin
            port_q     <= port_d;
            ip_q       <= ip_d;
            mac_q      <= mac_d;
            url_q      <= url_d;
            url_len_q  <= url_len_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata   = readdata_q;
    assign sh_port    = port_q;
    assign sh_ip      = ip_q;
    assign sh_mac     = mac_q;
    assign sh_url     = url_q;
    assign sh_url_len = url_len_q;

endmodule

// File: rtl/comp_reg_loader.sv
// Comparator configuration loader: commit FSM that copies the shadow file into
// the active comparator targets only while no packet is in flight.
//
// state   | meaning
// IDLE    | shadows writable, waiting for a commit request
// PENDING | commit requested, waiting for pkt_busy = 0
// LOAD    | shadow-to-active copy happens on the exit edge
// DONE    | update_done asserted for this one cycle
module comp_reg_loader (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         write,
    input  logic         read,
    input  logic [3:0]   address,
    input  logic [31:0]  writedata,
    output logic [31:0]  readdata,
    output logic         waitrequest,
    input  logic         pkt_busy,
    output logic [15:0]  port_value,
    output logic [31:0]  ip_value,
    output logic [47:0]  mac_value,
    output logic [127:0] url_value,
    output logic [4:0]   url_len,
    output logic         cfg_valid,
    output logic         update_done
);
    import sniffer_pkg::*;

    loader_state_e state_q, state_d;
    logic          wr_en, commit_req, load_en;

    logic [15:0]  sh_port;
    logic [31:0]  sh_ip;
    logic [47:0]  sh_mac;
    logic [127:0] sh_url;
    logic [4:0]   sh_url_len;

    logic [15:0]  port_q, port_d;
    logic [31:0]  ip_q, ip_d;
    logic [47:0]  mac_q, mac_d;
    logic [127:0] url_q, url_d;
    logic [4:0]   url_len_q, url_len_d;
    logic [7:0]   count_q, count_d;
    logic         valid_q, valid_d;

    assign wr_en = write && !waitrequest;

    cfg_shadow_file u_shadow (
        .clk            (clk),
        .n_rst          (n_rst),
        .wr_en          (wr_en),
        .rd_en          (read),
        .address        (address),
        .writedata      (writedata),
        .commit_pending (state_q != ST_IDLE),
        .cfg_valid      (valid_q),
        .commit_count   (count_q),
        .readdata       (readdata),
        .commit_req     (commit_req),
        .sh_port        (sh_port),
        .sh_ip          (sh_ip),
        .sh_mac         (sh_mac),
        .sh_url         (sh_url),
        .sh_url_len     (sh_url_len)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; pkt_busy is only looked at while PENDING.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (commit_req) state_d = ST_PENDING;
            ST_PENDING: if (!pkt_busy)  state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; mapped writes stall (not drop) while a commit is in progress.
    always_comb begin
        waitrequest = write && (address <= ADDR_CTRL) && (state_q != ST_IDLE);
        update_done = (state_q == ST_DONE);
        load_en     = (state_q == ST_LOAD);
    end

    // Active-register next state: everything changes together on the LOAD->DONE edge.
    always_comb begin
        port_d    = port_q;
        ip_d      = ip_q;
        mac_d     = mac_q;
        url_d     = url_q;
        url_len_d = url_len_q;
        count_d   = count_q;
        valid_d   = valid_q;
        if (load_en) begin
            port_d    = sh_port;
            ip_d      = sh_ip;
            mac_d     = sh_mac;
            url_d     = sh_url;
            url_len_d = sh_url_len;
            count_d   = count_q + 8'd1;
            valid_d   = 1'b1;
        end
    end

    // Active registers, commit counter and valid flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            port_q    <= '0;
            ip_q      <= '0;
            mac_q     <= '0;
            url_q     <= '0;
            url_len_q <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            port_q    <= port_d;
            ip_q      <= ip_d;
            mac_q     <= mac_d;
            url_q     <= url_d;
            url_len_q <= url_len_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
        end
    end

    assign port_value = port_q;
    assign ip_value   = ip_q;
    assign mac_value  = mac_q;
    assign url_value  = url_q;
    assign url_len    = url_len_q;
    assign cfg_valid  = valid_q;

endmodule

// File: tb/tb_comp_reg_loader.sv
// Directed bench for comp_reg_loader: inputs driven on the falling edge,
// outputs sampled on the falling edge or #1 after the rising edge.
module tb_comp_reg_loader;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         write;
    logic         read;
    logic [3:0]   address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         waitrequest;
    logic         pkt_busy;
    logic [15:0]  port_value;
    logic [31:0]  ip_value;
    logic [47:0]  mac_value;
    logic [127:0] url_value;
    logic [4:0]   url_len;
    logic         cfg_valid;
    logic         update_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comp_reg_loader dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .pkt_busy    (pkt_busy),
        .port_value  (port_value),
        .ip_value    (ip_value),
        .mac_value   (mac_value),
        .url_value   (url_value),
        .url_len     (url_len),
        .cfg_valid   (cfg_valid),
        .update_done (update_done)
    );

    task automatic avl_write(input logic [3:0] a, input logic [31:0] d);
        bit done;
        done = 0;
        @(negedge clk);
        write = 1'b1; address = a; writedata = d;
        for (int n = 0; n < 100 && !done; n++) begin
            if (!waitrequest) begin
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        #1 write = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL wr_accept addr=%0d got=timeout exp=accepted", a);
        end
    endtask

    task automatic avl_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        read = 1'b1; address = a;
        @(posedge clk);
        #1 read = 1'b0;
        @(negedge clk);
        d = readdata;
    endtask

    // Returns the number of falling edges after the accepting edge until update_done (first = 0).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (update_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; write = 0; read = 0; address = '0; writedata = '0; pkt_busy = 0;
        repeat (3) @(negedge clk);
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata got=%h exp=0", readdata); end
        checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL rst_waitreq got=%b exp=0", waitrequest); end
        checks++; if (update_done !== 1'b0) begin errors++; $display("FAIL rst_update_done got=%b exp=0", update_done); end
        checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL rst_cfg_valid got=%b exp=0", cfg_valid); end
        checks++;
        if ({port_value, ip_value, mac_value, url_value, url_len} !== '0) begin
            errors++; $display("FAIL rst_active got=%h/%h/%h/%h/%h exp=0", port_value, ip_value, mac_value, url_value, url_len);
        end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] rd;
        avl_write(4'd0, 32'h0000_0050);
        avl_write(4'd1, 32'hC0A8_0001);
        avl_write(4'd9, 32'h1);
        wait_done(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL basic_latency got=%0d exp=2", lat); end
        checks++; if (port_value !== 16'h0050) begin errors++; $display("FAIL basic_port got=%h exp=0050", port_value); end
        checks++; if (ip_value !== 32'hC0A8_0001) begin errors++; $display("FAIL basic_ip got=%h exp=c0a80001", ip_value); end
        checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL basic_cfg_valid got=%b exp=1", cfg_valid); end
        avl_read(4'd10, rd);
        checks++; if (rd !== 32'h0000_0102) begin errors++; $display("FAIL basic_status got=%h exp=00000102", rd); end
        // same-cycle read and write to PORT: read returns the old shadow
        @(negedge clk);
        write = 1'b1; read = 1'b1; address = 4'd0; writedata = 32'h1234;
        @(posedge clk);
        #1 write = 1'b0; read = 1'b0;
        @(negedge clk);
        checks++; if (readdata !== 32'h0000_0050) begin errors++; $display("FAIL rw_same_cycle got=%h exp=00000050", readdata); end
        avl_read(4'd0, rd);
        checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL rw_after got=%h exp=00001234", rd); end
    endtask

    task automatic test_busy_hold();
        int bad;
        logic [31:0] rd;
        @(negedge clk);
        pkt_busy = 1'b1;
        avl_write(4'd0, 32'h0443);
        avl_write(4'd9, 32'h1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (update_done !== 1'b0 || port_value !== 16'h0050) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL busy_hold bad_cycles got=%0d exp=0", bad); end
        avl_read(4'd10, rd);
        checks++; if (rd !== 32'h0000_0103) begin errors++; $display("FAIL busy_status got=%h exp=00000103", rd); end
        pkt_busy = 1'b0;
        @(negedge clk);
        checks++; if (update_done !== 1'b0) begin errors++; $display("FAIL busy_early_done got=%b exp=0", update_done); end
        @(negedge clk);
        checks++; if (update_done !== 1'b1) begin errors++; $display("FAIL busy_done got=%b exp=1", update_done); end
        checks++; if (port_value !== 16'h0443) begin errors++; $display("FAIL busy_port got=%h exp=0443", port_value); end
    endtask

    task automatic test_waitreq();
        int lat;
        int bad;
        bit accepted;
        logic [31:0] rd;
        avl_write(4'd2, 32'h2222_3333);
        avl_write(4'd3, 32'h0000_1111);
        avl_write(4'd9, 32'h1);
        wait_done(lat);
        checks++; if (mac_value !== 48'h1111_2222_3333) begin errors++; $display("FAIL wr_mac_commit got=%h exp=111122223333", mac_value); end
        @(negedge clk);
        pkt_busy = 1'b1;
        avl_write(4'd9, 32'h1);
        @(negedge clk);
        write = 1'b1; address = 4'd2; writedata = 32'hAAAA_BBBB;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (waitrequest !== 1'b1 || mac_value !== 48'h1111_2222_3333) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wr_stall bad_cycles got=%0d exp=0", bad); end
        pkt_busy = 1'b0;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!waitrequest) begin
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 write = 1'b0;
        checks++; if (!accepted) begin errors++; $display("FAIL wr_release got=stalled exp=accepted"); end
        @(negedge clk);
        checks++; if (mac_value !== 48'h1111_2222_3333) begin errors++; $display("FAIL wr_mac_active got=%h exp=111122223333", mac_value); end
        avl_read(4'd2, rd);
        checks++; if (rd !== 32'hAAAA_BBBB) begin errors++; $display("FAIL wr_mac_shadow got=%h exp=aaaabbbb", rd); end
    endtask

    task automatic test_url_clear();
        int lat;
        logic [31:0] rd;
        avl_write(4'd4, 32'h7777_772E);
        avl_write(4'd5, 32'h6578_616D);
        avl_write(4'd6, 32'h706C_652E);
        avl_write(4'd7, 32'h636F_6D2F);
        avl_write(4'd8, 32'd25);
        avl_read(4'd8, rd);
        checks++; if (rd !== 32'd16) begin errors++; $display("FAIL url_len_sat got=%0d exp=16", rd); end
        avl_read(4'd12, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", rd); end
        avl_write(4'd9, 32'h1);
        wait_done(lat);
        checks++;
        if (url_value !== 128'h7777_772E_6578_616D_706C_652E_636F_6D2F || url_len !== 5'd16) begin
            errors++; $display("FAIL url_commit got=%h/%0d exp=7777772e6578616d706c652e636f6d2f/16", url_value, url_len);
        end
        avl_write(4'd9, 32'h3);
        wait_done(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL clear_latency got=%0d exp=2", lat); end
        checks++;
        if ({port_value, ip_value, mac_value, url_value, url_len} !== '0) begin
            errors++; $display("FAIL clear_active got=%h/%h/%h/%h/%h exp=0", port_value, ip_value, mac_value, url_value, url_len);
        end
        avl_read(4'd10, rd);
        checks++; if (rd !== 32'h0000_0602) begin errors++; $display("FAIL clear_status got=%h exp=00000602", rd); end
    endtask

    task automatic test_wrap();
        int lat;
        int bad;
        logic [31:0] rd;
        pulse_reset();
        avl_write(4'd0, 32'h7);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            avl_write(4'd9, 32'h1);
            wait_done(lat);
            if (lat != 2) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_latency bad_commits got=%0d exp=0", bad); end
        avl_read(4'd10, rd);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL wrap_status got=%h exp=00000002", rd); end
        checks++; if (cfg_valid !== 1'b1 || port_value !== 16'h7) begin errors++; $display("FAIL wrap_active got=%b/%h exp=1/0007", cfg_valid, port_value); end
    endtask

    task automatic test_reset_mid_commit();
        int lat;
        bit seen;
        logic [31:0] rd;
        avl_write(4'd0, 32'hBEEF);
        avl_write(4'd9, 32'h1);
        wait_done(lat);
        checks++; if (port_value !== 16'hBEEF) begin errors++; $display("FAIL mid_pre_port got=%h exp=beef", port_value); end
        avl_read(4'd0, rd);
        avl_write(4'd0, 32'h1);
        avl_write(4'd9, 32'h1);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        checks++;
        if ({port_value, ip_value, mac_value, url_value, url_len, cfg_valid, update_done, waitrequest, readdata} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs got=%h/%b/%b/%h exp=0", port_value, cfg_valid, update_done, readdata);
        end
        @(negedge clk);
        n_rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (update_done) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL mid_no_done got=pulse exp=none"); end
        avl_read(4'd10, rd);
        checks++; if (rd !== 32'h0 || port_value !== 16'h0) begin errors++; $display("FAIL mid_status got=%h/%h exp=0/0", rd, port_value); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_hold();
        test_waitreq();
        test_url_clear();
        test_wrap();
        test_reset_mid_commit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comp_reg_loader.md
# comp_reg_loader

Configuration sequencer for the match comparators. Accepts Avalon-MM slave writes of port, IP, MAC and URL match targets into shadow registers, then on a commit request transfers them atomically into the active comparator registers. The transfer happens only while no packet is in flight, after which it pulses `update_done` to the top-level controller. Sits between the Avalon slave fabric and the port/IP/MAC/URL comparators.

## Interface
- No parameters; all widths fixed.
- `clk`  in  1  system clock
- `n_rst`  in  1  asynchronous active-low reset
- `write`  in  1  Avalon write strobe
- `read`  in  1  Avalon read strobe
- `address`  in  4  Avalon word address
- `writedata`  in  32  Avalon write data
- `readdata`  out  32  registered read data; fixed read latency 1
- `waitrequest`  out  1  stalls shadow writes during a pending commit
- `pkt_busy`  in  1  high while the controller has a packet between SOP and the match decision
- `port_value`  out  16  active port target
- `ip_value`  out  32  active IP target
- `mac_value`  out  48  active MAC target
- `url_value`  out  128  active URL target; byte 0 in [127:120]
- `url_len`  out  5  active URL length, 0..16
- `cfg_valid`  out  1  high once at least one commit has completed
- `update_done`  out  1  one-cycle pulse after each commit

## Operation
- Address map (word addresses):
  - 0 PORT[15:0]
  - 1 IP
  - 2 MAC[31:0]
  - 3 MAC[47:32]
  - 4–7 URL words 0–3; word 0 holds bytes 0–3, first byte in writedata[31:24]
  - 8 URL_LEN[4:0]; values above 16 are stored as 16
  - 9 CTRL: bit1 = clear all shadows to 0; bit0 = commit
  - 10 STATUS (read-only): bit0 = commit pending, bit1 = cfg_valid, [15:8] = commit count
  - 11–15: writes ignored, reads return 0.
- Reads return shadow contents, never active contents. Unused bits read 0.
- FSM states are IDLE, PENDING, LOAD, DONE.
  - IDLE -> PENDING on an accepted CTRL write with bit0 = 1.
  - PENDING -> LOAD when `pkt_busy` = 0; otherwise hold in PENDING.
  - LOAD -> DONE unconditionally. The shadow-to-active copy happens at the LOAD->DONE edge.
  - DONE -> IDLE unconditionally. `update_done` = 1 during the DONE cycle; `cfg_valid` is set at the same time and stays set.
- The commit count is 8 bits and increments on entry to DONE; it wraps 255 -> 0.
- Boundary conditions:
  - CTRL write with bit0 = 1 and bit1 = 1: the clear is applied first, so the commit loads zeros.
  - Any write (addresses 0–9) while the FSM is not in IDLE: `waitrequest` = 1 and the write is held, not dropped. Reads never stall.
  - `pkt_busy` rising in the same cycle the FSM is in PENDING with `pkt_busy` = 0: the FSM still moves to LOAD, because the decision samples `pkt_busy` in PENDING only.
  - Reset mid-commit: the FSM returns to IDLE and all shadow, active, count and flag registers clear; no `update_done` is issued.
- Reset values: every output is 0, including `readdata`, `waitrequest`, `update_done` and `cfg_valid`.

## Timing
- The commit write is accepted at edge E0, and the FSM is in PENDING during the following cycle.
- With `pkt_busy` = 0:
  - E1 -> LOAD.
  - E2: active outputs update and the FSM enters DONE; `update_done` is high for the cycle after E2.
  - E3 -> IDLE.
- Minimum commit latency is 2 edges from acceptance to the `update_done` cycle. Each cycle of `pkt_busy` = 1 in PENDING adds one cycle.
- Active outputs are stable whenever `update_done` is high and never change outside the LOAD->DONE edge.
- `readdata` is valid one cycle after `read` is sampled high. When `read` and `write` target the same address in the same cycle, the read returns the pre-write value.
- `waitrequest` is combinational from state and `write`.

## Structure
- Shared package (`sniffer_pkg`) holds:
  - address constants for registers 0–10
  - CTRL/STATUS bit positions
  - the loader state enum.
- One sub-module: `cfg_shadow_file`. It holds the shadow registers, decode, URL_LEN saturation, clear, and read mux.
- The top level holds the FSM, the active registers and the counters.

## Test plan
- Reset, then write PORT=0x0050, IP=0xC0A80001 and CTRL=0x1 with `pkt_busy` = 0:
  - `update_done` pulses 2 edges after the CTRL write.
  - `port_value` = 0x0050, `ip_value` = 0xC0A80001, `cfg_valid` = 1, STATUS[15:8] = 1.
- Hold `pkt_busy` = 1 for 10 cycles after a commit:
  - FSM stays in PENDING and active outputs are unchanged.
  - `update_done` occurs 2 cycles after `pkt_busy` falls.
- Write a MAC during PENDING:
  - `waitrequest` = 1 until IDLE, then the write lands in the shadow.
  - The active MAC keeps the previously committed value.
- Write URL_LEN=25, then read address 8 -> 16. Write CTRL=0x3 -> all active outputs become 0 and `update_done` pulses.
- Perform 256 commits -> STATUS[15:8] = 0 and `cfg_valid` = 1.
- Assert `n_rst` during LOAD -> all outputs 0 and no `update_done` follows.
